// File: rtl/sig_period_meter.sv
// Period and high-time meter for a slow signal sampled in the clk_i domain.
// Reports each completed period with a one-cycle strobe and an expected-value match flag.
module sig_period_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             sig_i,
  input  logic [CNT_W-1:0] exp_period_i,
  input  logic [CNT_W-1:0] exp_high_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             match_o,
  output logic             stall_o
);

  typedef enum logic {
    ST_IDLE,
    ST_MEASURE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_per_cnt;
  logic [CNT_W-1:0]       r_hi_cnt;
  logic [CNT_W-1:0]       r_period;
  logic [CNT_W-1:0]       r_high;
  logic                   r_valid;
  logic                   r_match;
  logic                   r_stall;

  logic                   w_s;
  logic                   w_rise;
  logic [CNT_W:0]         w_hi_diff;
  logic                   w_match;
  state_t                 w_state_next;
  logic [CNT_W-1:0]       w_per_next;
  logic [CNT_W-1:0]       w_hi_next;
  logic [CNT_W-1:0]       w_period_next;
  logic [CNT_W-1:0]       w_high_next;
  logic                   w_valid_next;
  logic                   w_match_next;
  logic                   w_stall_next;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_d;

  // NOTE: every state-holding flop is assigned with <= so all flops update from the same pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_i};
      r_s_d  <= w_s;
    end
  end

  // Absolute high-time error, one bit wider so the subtraction cannot wrap.
  always_comb begin
    if (r_hi_cnt >= exp_high_i) begin
      w_hi_diff = {1'b0, r_hi_cnt} - {1'b0, exp_high_i};
    end else begin
      w_hi_diff = {1'b0, exp_high_i} - {1'b0, r_hi_cnt};
    end
  end

  assign w_match = (r_per_cnt == exp_period_i) && (w_hi_diff <= (CNT_W+1)'(1));

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next  = r_state;
    w_per_next    = r_per_cnt;
    w_hi_next     = r_hi_cnt;
    w_period_next = r_period;
    w_high_next   = r_high;
    w_valid_next  = 1'b0;
    w_match_next  = r_match;
    w_stall_next  = r_stall;

    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_next = ST_MEASURE;
          w_per_next   = CNT_ONE;
          w_hi_next    = CNT_ONE;
          w_stall_next = 1'b0;
        end
      end
      ST_MEASURE: begin
        if (w_rise) begin
          w_period_next = r_per_cnt;
          w_high_next   = r_hi_cnt;
          w_valid_next  = 1'b1;
          w_match_next  = w_match;
          w_per_next    = CNT_ONE;
          w_hi_next     = CNT_ONE;
        end else if (r_per_cnt == CNT_MAX) begin
          // Counter saturated: drop the measurement and wait for a fresh edge to re-arm.
          w_state_next = ST_IDLE;
          w_stall_next = 1'b1;
        end else begin
          w_per_next = r_per_cnt + CNT_ONE;
          w_hi_next  = r_hi_cnt + {{(CNT_W-1){1'b0}}, w_s};
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= ST_IDLE;
      r_per_cnt <= '0;
      r_hi_cnt  <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_match   <= 1'b0;
      r_stall   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_per_cnt <= w_per_next;
      r_hi_cnt  <= w_hi_next;
      r_period  <= w_period_next;
      r_high    <= w_high_next;
      r_valid   <= w_valid_next;
      r_match   <= w_match_next;
      r_stall   <= w_stall_next;
    end
  end

  assign period_o = r_period;
  assign high_o   = r_high;
  assign valid_o  = r_valid;
  assign match_o  = r_match;
  assign stall_o  = r_stall;

endmodule

// File: tb/tb_sig_period_meter.sv
// Directed self-checking bench for sig_period_meter with a narrow counter so saturation is reachable.
module tb_sig_period_meter;

  localparam int CNT_W = 4;
  localparam int SYNC  = 2;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             sig_i;
  logic [CNT_W-1:0] exp_period_i;
  logic [CNT_W-1:0] exp_high_i;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             valid_o;
  logic             match_o;
  logic             stall_o;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rise2_cyc;

  // Written only by the monitor; the stimulus thread reads them.
  int strobe_q[$];
  int stall_q[$];
  logic stall_prev = 1'b0;

  sig_period_meter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .sig_i        (sig_i),
    .exp_period_i (exp_period_i),
    .exp_high_i   (exp_high_i),
    .period_o     (period_o),
    .high_o       (high_o),
    .valid_o      (valid_o),
    .match_o      (match_o),
    .stall_o      (stall_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (valid_o) strobe_q.push_back(cyc);
    if (stall_o && !stall_prev) stall_q.push_back(cyc);
    stall_prev = stall_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    reset_i = 1'b1;
    sig_i   = 1'b0;
    repeat (2) step();
    reset_i = 1'b0;
  endtask

  // n periods of p cycles with h cycles high, then tail cycles low.
  task automatic drive_periods(input int p, input int h, input int n, input int tail);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < p; c++) begin
        sig_i = (c < h);
        if (i == 1 && c == 0) rise2_cyc = cyc;
        step();
      end
    end
    sig_i = 1'b0;
    repeat (tail) step();
  endtask

  task automatic check_gaps(input string tag, input int base, input int gap);
    for (int i = base + 1; i < strobe_q.size(); i++) begin
      check(tag, strobe_q[i] - strobe_q[i-1], gap);
    end
  endtask

  initial begin
    int base;
    int mark;

    reset_i      = 1'b1;
    sig_i        = 1'b0;
    exp_period_i = 4'd5;
    exp_high_i   = 4'd3;

    // Reset held while the input toggles.
    repeat (3) begin
      sig_i = ~sig_i;
      step();
    end
    check("rst_period", period_o, 0);
    check("rst_high", high_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_match", match_o, 0);
    check("rst_stall", stall_o, 0);

    // Divide-by-5, 3 high / 2 low straight out of reset: 6 rises give 5 results.
    base = strobe_q.size();
    reset_i = 1'b0;
    drive_periods(5, 3, 6, 5);
    check("div5_count", strobe_q.size() - base, 5);
    if (strobe_q.size() > base) check("div5_latency", strobe_q[base] - rise2_cyc, SYNC + 1);
    check_gaps("div5_gap", base, 5);
    check("div5_period", period_o, 5);
    check("div5_high", high_o, 3);
    check("div5_match", match_o, 1);

    // Period mismatch.
    apply_reset();
    base = strobe_q.size();
    drive_periods(6, 3, 3, 5);
    check("mis_p_count", strobe_q.size() - base, 2);
    check("mis_p_period", period_o, 6);
    check("mis_p_high", high_o, 3);
    check("mis_p_match", match_o, 0);

    // High time off by 2: mismatch.
    exp_high_i = 4'd2;
    apply_reset();
    drive_periods(5, 4, 3, 5);
    check("mis_h_high", high_o, 4);
    check("mis_h_match", match_o, 0);

    // High time off by +1 and by -1: both inside tolerance.
    exp_high_i = 4'd3;
    apply_reset();
    drive_periods(5, 4, 3, 5);
    check("tol_plus_match", match_o, 1);
    exp_high_i = 4'd5;
    apply_reset();
    drive_periods(5, 4, 3, 5);
    check("tol_minus_match", match_o, 1);

    // Stall: one rise then low; 15 counted cycles saturate the 4-bit counter.
    exp_high_i = 4'd3;
    apply_reset();
    base = strobe_q.size();
    mark = stall_q.size();
    sig_i = 1'b1;
    rise2_cyc = cyc;
    step();
    step();
    sig_i = 1'b0;
    repeat (22) step();
    check("stall_set", stall_o, 1);
    check("stall_count", stall_q.size() - mark, 1);
    if (stall_q.size() > mark) check("stall_time", stall_q[mark] - rise2_cyc, SYNC + 1 + 15);
    check("stall_no_valid", strobe_q.size() - base, 0);
    sig_i = 1'b1;
    repeat (3) step();
    sig_i = 1'b0;
    repeat (2) step();
    check("stall_cleared", stall_o, 0);
    check("rearm_no_valid", strobe_q.size() - base, 0);
    drive_periods(5, 3, 1, 5);
    check("recover_count", strobe_q.size() - base, 1);
    check("recover_period", period_o, 5);
    check("recover_high", high_o, 3);

    // Reset three cycles into a period-8 measurement.
    exp_period_i = 4'd8;
    exp_high_i   = 4'd4;
    apply_reset();
    base = strobe_q.size();
    mark = 0;
    for (int t = 0; t < 32; t++) begin
      sig_i   = ((t % 8) < 4);
      reset_i = (t == 3 || t == 4);
      if (t == 16) mark = cyc;
      step();
    end
    sig_i   = 1'b0;
    reset_i = 1'b0;
    repeat (5) step();
    check("midrst_count", strobe_q.size() - base, 2);
    if (strobe_q.size() > base) check("midrst_first", strobe_q[base] - mark, SYNC + 1);
    check("midrst_period", period_o, 8);
    check("midrst_high", high_o, 4);
    check("midrst_match", match_o, 1);

    // Minimum period: 1 high, 1 low.
    exp_period_i = 4'd2;
    exp_high_i   = 4'd1;
    apply_reset();
    base = strobe_q.size();
    drive_periods(2, 1, 8, 4);
    check("min_count", strobe_q.size() - base, 7);
    check_gaps("min_gap", base, 2);
    check("min_period", period_o, 2);
    check("min_high", high_o, 1);
    check("min_match", match_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sig_period_meter.md
# sig_period_meter

Measures the period and high time of a slow, clock-derived signal (for example a divided clock) in units of `clk_i` cycles. It reports each completed period with a one-cycle valid strobe and flags agreement with expected values. It is the receive-side checker for the team's clock divider blocks and sits in test and monitor logic. It is a one-clock synchronous design and never uses the measured signal as a clock.

## Interface
- `CNT_W`, default 16: width of the period/high counters and results.
- `SYNC_STAGES`, default 2, minimum 2: synchronizer depth on `sig_i`.

- `clk_i`  input  1  sampling clock; all flops on the rising edge.
- `reset_i`  input  1  synchronous, active-high reset.
- `sig_i`  input  1  measured signal; may be asynchronous to `clk_i`.
- `exp_period_i`  input  CNT_W  expected period in `clk_i` cycles; quasi-static.
- `exp_high_i`  input  CNT_W  expected high time in `clk_i` cycles; quasi-static.
- `period_o`  output  CNT_W  last measured period.
- `high_o`  output  CNT_W  last measured high time.
- `valid_o`  output  1  one-cycle strobe: `period_o` and `high_o` updated this cycle.
- `match_o`  output  1  comparison result, qualified by `valid_o`.
- `stall_o`  output  1  no rising edge seen for 2^CNT_W−1 cycles; sticky until the next rise.

## Operation
- **Synchronizer.** `sig_i` passes through a `SYNC_STAGES` flop chain; `s` is the last stage. A further flop holds `s_d`. Then `rise = s & ~s_d`.
- **State machine, IDLE.** This is the reset state. On `rise`: go to MEASURE, set `per_cnt = 1`, `hi_cnt = 1`. No result is produced, because the first edge only arms the meter.
- **State machine, MEASURE**, on a cycle without `rise`:
  - `per_cnt += 1`.
  - `hi_cnt += s`.
- **State machine, MEASURE**, on `rise`:
  - `period_o = per_cnt`, `high_o = hi_cnt`, `valid_o = 1`.
  - `match_o = (per_cnt == exp_period_i) && (|hi_cnt − exp_high_i| <= 1)`.
  - Set `per_cnt = 1`, `hi_cnt = 1`, and stay in MEASURE.
  - The ±1 tolerance on high time absorbs half-cycle duty (e.g. odd divisors).
- **Saturation.** If `per_cnt` reaches 2^CNT_W−1 in MEASURE, go to IDLE with `stall_o = 1` and no `valid_o`. `stall_o` clears on the next `rise`, which re-arms the meter as in IDLE.
- **Stuck signal.** A constant `sig_i` (high or low) ends in stall. `hi_cnt` never exceeds `per_cnt`, so it cannot overflow.
- **Arithmetic.** All compares are unsigned at CNT_W bits. The high-time difference is computed at CNT_W+1 bits to avoid wrap.
- **Held outputs.** `period_o`, `high_o` and `match_o` hold between strobes. `match_o` is only meaningful when `valid_o` = 1.
- **Reset.** `reset_i` at any time:
  - Clears the synchronizer, `s_d`, counters and state to IDLE.
  - Drives `period_o`, `high_o`, `valid_o`, `match_o` and `stall_o` to 0.
  - The measurement in progress is discarded. The first rise after reset only arms the meter.
- **Limits.** Minimum measurable period is 2 cycles. The high time must be at least 1 cycle and at least 1 cycle shorter than the period. Pulses narrower than one `clk_i` period may be missed; this is not an error case.

## Timing
- **Latency.** If `sig_i` is first sampled high at edge k, then `s` rises after edge k+SYNC_STAGES−1, and `valid_o` is high in the cycle after edge k+SYNC_STAGES.
- **Throughput.** One result per `sig_i` period. `valid_o` is never high on two consecutive cycles, since the period is at least 2.
- **Synchronous measurement.** For an ideal synchronous signal with period P and high time H cycles, steady-state results are exactly `period_o = P`, `high_o = H`.
- **Stall timing.** `stall_o` asserts in the cycle after `per_cnt` reaches 2^CNT_W−1.
- **Output registration.** All outputs are registered; there is no combinational path from an input to an output.

## Test plan
- **Reset.** Hold `reset_i` for 3 cycles while `sig_i` toggles. Required: all outputs 0, and no `valid_o` until the second rise after release.
- **Divide-by-5, 3 high / 2 low.** Drive synchronously with `exp_period_i = 5`, `exp_high_i = 3`. Required: `valid_o` every 5 cycles with `period_o = 5`, `high_o = 3`, `match_o = 1`. First strobe at SYNC_STAGES+1 cycles after the second rise.
- **Mismatch.** Drive period 6, high 3 with `exp_period_i = 5`, `exp_high_i = 3`. Required: `period_o = 6`, `match_o = 0`. Then with period 5, high 5−1=4 against `exp_high_i = 2`: `match_o = 0` (difference 2).
- **Stall and recovery.** With `CNT_W = 4`, hold `sig_i` low after a rise. Required: `stall_o = 1` at 15 counted cycles with no `valid_o`. On the next rise `stall_o` clears, and the following rise produces a valid result.
- **Mid-measurement reset.** Period 8, high 4; assert `reset_i` 3 cycles after a rise. Required: no strobe for the interrupted period, then `period_o = 8`, `high_o = 4` after two further rises.
- **Minimum period.** Drive period 2, high 1. Required: `valid_o` every other cycle with `period_o = 2`, `high_o = 1`.
